countdown_timer: RTL and testbench

- Down-counting HH:MM:SS timer, the decrementing counterpart of the up-counting time-of-day timer.
- Driven from the system clock with a single-cycle 1 Hz `tick` enable; no derived clocks.
- Outputs are binary sec/min/hrs bytes in the same format the seven-segment display path already consumes, plus expiry status and a blinking buzzer line.
- Time is set with increment pulses from the button front end, then started, paused, resumed and cleared by the user.

---
 rtl/countdown_timer.sv | 196 +++++++++++++++++++
 tb/tb_countdown_timer.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/countdown_timer.sv
// Down-counting HH:MM:SS timer. It is advanced by a 1 Hz tick enable and controlled by button pulses.
// An expiry hold with a blinking buzzer ends with an automatic reload of the preset time.
module countdown_timer #(
    parameter int HR_MAX      = 23,
    parameter int EXPIRE_HOLD = 30
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       inc_min,
    input  logic       inc_hr,
    input  logic       start_stop,
    input  logic       clear,
    output logic [7:0] sec,
    output logic [7:0] min,
    output logic [7:0] hrs,
    output logic       running,
    output logic       expired,
    output logic       buzzer
);

    localparam int                HOLD_W      = $clog2(EXPIRE_HOLD + 1);
    localparam logic [7:0]        HR_MAX_C    = 8'(HR_MAX);
    localparam logic [7:0]        SIXTY_M1_C  = 8'd59;
    localparam logic [HOLD_W-1:0] HOLD_LAST_C = HOLD_W'(EXPIRE_HOLD);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_PAUSE   = 2'd2,
        ST_EXPIRED = 2'd3
    } state_t;

    state_t            state_r, state_s;
    logic [7:0]        pre_sec_r, pre_min_r, pre_hrs_r;
    logic [7:0]        pre_sec_s, pre_min_s, pre_hrs_s;
    logic [7:0]        sec_s, min_s, hrs_s;
    logic [7:0]        dec_sec_s, dec_min_s, dec_hrs_s;
    logic              dec_zero_s, cnt_zero_s;
    logic              blink_r, blink_s;
    logic [HOLD_W-1:0] hold_r, hold_s, hold_inc_s;

    // Mixed-radix decrement of the current count; it saturates at zero.
    always_comb begin
        dec_sec_s = sec;
        dec_min_s = min;
        dec_hrs_s = hrs;
        if (sec != 8'd0) begin
            dec_sec_s = sec - 8'd1;
        end else if (min != 8'd0) begin
            dec_sec_s = SIXTY_M1_C;
            dec_min_s = min - 8'd1;
        end else if (hrs != 8'd0) begin
            dec_sec_s = SIXTY_M1_C;
            dec_min_s = SIXTY_M1_C;
            dec_hrs_s = hrs - 8'd1;
        end else begin
            dec_sec_s = 8'd0;
        end
        dec_zero_s = (dec_sec_s == 8'd0) && (dec_min_s == 8'd0) && (dec_hrs_s == 8'd0);
        cnt_zero_s = (sec == 8'd0) && (min == 8'd0) && (hrs == 8'd0);
        hold_inc_s = hold_r + HOLD_W'(1);
    end

    // Next-state logic. Priority is clear, then start_stop, then tick, then the increment pulses.
    always_comb begin
        state_s   = state_r;
        sec_s     = sec;
        min_s     = min;
        hrs_s     = hrs;
        pre_sec_s = pre_sec_r;
        pre_min_s = pre_min_r;
        pre_hrs_s = pre_hrs_r;
        blink_s   = blink_r;
        hold_s    = hold_r;
        case (state_r)
            ST_IDLE: begin
                if (clear) begin
                    sec_s     = 8'd0;
                    min_s     = 8'd0;
                    hrs_s     = 8'd0;
                    pre_sec_s = 8'd0;
                    pre_min_s = 8'd0;
                    pre_hrs_s = 8'd0;
                end else if (start_stop) begin
                    if (!cnt_zero_s) begin
                        pre_sec_s = sec;
                        pre_min_s = min;
                        pre_hrs_s = hrs;
                        state_s   = ST_RUN;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end else begin
                    if (inc_min) begin
                        min_s = (min == SIXTY_M1_C) ? 8'd0 : min + 8'd1;
                    end else begin
                        min_s = min;
                    end
                    if (inc_hr) begin
                        hrs_s = (hrs == HR_MAX_C) ? 8'd0 : hrs + 8'd1;
                    end else begin
                        hrs_s = hrs;
                    end
                end
            end
            ST_RUN: begin
                if (clear) begin
                    sec_s   = pre_sec_r;
                    min_s   = pre_min_r;
                    hrs_s   = pre_hrs_r;
                    state_s = ST_IDLE;
                end else if (start_stop) begin
                    state_s = ST_PAUSE;
                end else if (tick) begin
                    sec_s = dec_sec_s;
                    min_s = dec_min_s;
                    hrs_s = dec_hrs_s;
                    if (dec_zero_s) begin
                        state_s = ST_EXPIRED;
                        blink_s = 1'b1;
                        hold_s  = '0;
                    end else begin
                        state_s = ST_RUN;
                    end
                end else begin
                    state_s = ST_RUN;
                end
            end
            ST_PAUSE: begin
                if (clear) begin
                    sec_s   = pre_sec_r;
                    min_s   = pre_min_r;
                    hrs_s   = pre_hrs_r;
                    state_s = ST_IDLE;
                end else if (start_stop) begin
                    state_s = ST_RUN;
                end else begin
                    state_s = ST_PAUSE;
                end
            end
            ST_EXPIRED: begin
                if (clear || start_stop || (tick && (hold_inc_s == HOLD_LAST_C))) begin
                    sec_s   = pre_sec_r;
                    min_s   = pre_min_r;
                    hrs_s   = pre_hrs_r;
                    blink_s = 1'b0;
                    hold_s  = '0;
                    state_s = ST_IDLE;
                end else if (tick) begin
                    blink_s = ~blink_r;
                    hold_s  = hold_inc_s;
                end else begin
                    state_s = ST_EXPIRED;
                end
            end
            default: begin
                state_s = ST_IDLE;
                blink_s = 1'b0;
                hold_s  = '0;
            end
        endcase
    end

    // State, count, preset and registered status outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r   <= ST_IDLE;
            sec       <= 8'd0;
            min       <= 8'd0;
            hrs       <= 8'd0;
            pre_sec_r <= 8'd0;
            pre_min_r <= 8'd0;
            pre_hrs_r <= 8'd0;
            blink_r   <= 1'b0;
            hold_r    <= '0;
            running   <= 1'b0;
            expired   <= 1'b0;
            buzzer    <= 1'b0;
        end else begin
            state_r   <= state_s;
            sec       <= sec_s;
            min       <= min_s;
            hrs       <= hrs_s;
            pre_sec_r <= pre_sec_s;
            pre_min_r <= pre_min_s;
            pre_hrs_r <= pre_hrs_s;
            blink_r   <= blink_s;
            hold_r    <= hold_s;
            running   <= (state_s == ST_RUN);
            expired   <= (state_s == ST_EXPIRED);
            buzzer    <= (state_s == ST_EXPIRED) && blink_s;
        end
    end

endmodule

// File: tb/tb_countdown_timer.sv
// Directed self-checking bench for countdown_timer: it sets the time, then covers run, pause, expiry,
// wrap and async reset, with hand-computed expectations.
module tb_countdown_timer;

    logic       clk = 1'b0;
    logic       reset, tick, inc_min, inc_hr, start_stop, clear;
    logic [7:0] sec, min, hrs;
    logic       running, expired, buzzer;
    int         checks = 0;
    int         errors = 0;

    countdown_timer #(.HR_MAX(23), .EXPIRE_HOLD(30)) dut (
        .clk(clk), .reset(reset), .tick(tick), .inc_min(inc_min), .inc_hr(inc_hr),
        .start_stop(start_stop), .clear(clear), .sec(sec), .min(min), .hrs(hrs),
        .running(running), .expired(expired), .buzzer(buzzer)
    );

    always #5 clk = ~clk;

    // Called at a negedge: drive the pulses for one rising edge, then return on the next negedge.
    task automatic cyc(input logic t, input logic im, input logic ih, input logic ss, input logic cl);
        tick = t; inc_min = im; inc_hr = ih; start_stop = ss; clear = cl;
        @(negedge clk);
        tick = 1'b0; inc_min = 1'b0; inc_hr = 1'b0; start_stop = 1'b0; clear = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_time(input string tag, input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
        chk(tag, {8'd0, hrs, min, sec}, {8'd0, h, m, s});
    endtask

    task automatic chk_flags(input string tag, input logic r, input logic e, input logic b);
        chk(tag, {29'd0, running, expired, buzzer}, {29'd0, r, e, b});
    endtask

    initial begin
        reset = 1'b1; tick = 1'b0; inc_min = 1'b0; inc_hr = 1'b0; start_stop = 1'b0; clear = 1'b0;
        @(negedge clk);
        chk_time("reset_time", 8'd0, 8'd0, 8'd0);
        chk_flags("reset_flags", 1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        @(negedge clk);

        // Set 01:03:00, start, then one tick
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk_time("set_0103", 8'd1, 8'd3, 8'd0);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk_time("run_0103", 8'd1, 8'd3, 8'd0);
        chk_flags("run_flags", 1'b1, 1'b0, 1'b0);
        ticks(1);
        chk_time("first_tick", 8'd1, 8'd2, 8'd59);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk_time("clear_reload", 8'd1, 8'd3, 8'd0);
        chk_flags("clear_flags", 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk_time("clear_idle", 8'd0, 8'd0, 8'd0);

        // Wrap of minutes and hours; zero start is ignored
        for (int i = 0; i < 59; i++) cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk_time("min_59", 8'd0, 8'd59, 8'd0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk_time("min_wrap", 8'd0, 8'd0, 8'd0);
        for (int i = 0; i < 23; i++) cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        chk_time("hr_23", 8'd23, 8'd0, 8'd0);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        chk_time("hr_wrap", 8'd0, 8'd0, 8'd0);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk_flags("zero_start", 1'b0, 1'b0, 1'b0);
        chk_time("zero_start_t", 8'd0, 8'd0, 8'd0);

        // Expiry from 00:01:00 and the automatic return after the hold
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        ticks(59);
        chk_time("at_0001", 8'd0, 8'd0, 8'd1);
        ticks(1);
        chk_time("expire_t", 8'd0, 8'd0, 8'd0);
        chk_flags("expire_f", 1'b0, 1'b1, 1'b1);
        ticks(1);
        chk_flags("blink_off", 1'b0, 1'b1, 1'b0);
        ticks(1);
        chk_flags("blink_on", 1'b0, 1'b1, 1'b1);
        ticks(27);
        chk_flags("hold_29", 1'b0, 1'b1, 1'b0);
        chk_time("hold_29_t", 8'd0, 8'd0, 8'd0);
        ticks(1);
        chk_flags("hold_done", 1'b0, 1'b0, 1'b0);
        chk_time("hold_reload", 8'd0, 8'd1, 8'd0);

        // Pause / resume / clear at 00:05:00
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk_flags("pause_f", 1'b0, 1'b0, 1'b0);
        ticks(10);
        chk_time("pause_hold", 8'd0, 8'd5, 8'd0);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk_flags("resume_f", 1'b1, 1'b0, 1'b0);
        ticks(1);
        chk_time("resume_tick", 8'd0, 8'd4, 8'd59);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk_time("pause_clear", 8'd0, 8'd5, 8'd0);

        // Hour borrow and coincident pulses
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        ticks(1);
        chk_time("hr_borrow", 8'd0, 8'd59, 8'd59);
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        chk_time("tick_ss_t", 8'd0, 8'd59, 8'd59);
        chk_flags("tick_ss_f", 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        chk_time("tick_clr_t", 8'd1, 8'd0, 8'd0);
        chk_flags("tick_clr_f", 1'b0, 1'b0, 1'b0);

        // Both increments together, then async reset mid-run at 00:03:17
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        chk_time("both_inc", 8'd1, 8'd1, 8'd0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        ticks(43);
        chk_time("pre_reset", 8'd0, 8'd3, 8'd17);
        #2 reset = 1'b1;
        #1;
        chk_time("async_rst_t", 8'd0, 8'd0, 8'd0);
        chk_flags("async_rst_f", 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk_flags("post_rst_ss", 1'b0, 1'b0, 1'b0);
        chk_time("post_rst_t", 8'd0, 8'd0, 8'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
